// File: rtl/fetch_pkg.sv
// Shared types and sizing for the instruction-fetch stage of the 9-bit CPU.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  localparam int LUT_ENTRIES = 4;
  localparam int TARG_W      = 2;   // matches the decoder's TargSel width
  localparam int DEF_PC_W    = 10;
  localparam int DEF_CNT_W   = 16;

endpackage

// File: rtl/target_lut.sv
// Jump-target table: one write port, one combinational read port, async clear.
module target_lut
  import fetch_pkg::*;
#(
  parameter int PC_W = DEF_PC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [TARG_W-1:0] wr_addr,
  input  logic [PC_W-1:0]   wr_data,
  input  logic [TARG_W-1:0] rd_addr,
  output logic [PC_W-1:0]   rd_data
);

  logic [PC_W-1:0] mem_q [LUT_ENTRIES];
  logic [PC_W-1:0] mem_d [LUT_ENTRIES];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LUT_ENTRIES; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, picks next-PC from decoder/ALU inputs, sequences
// start/halt/restart and counts RUN cycles.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int PC_W  = DEF_PC_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic              Stall,
  input  logic              Jump,
  input  logic              BranchEn,
  input  logic [TARG_W-1:0] TargSel,
  input  logic              Ack,
  input  logic              Taken,
  input  logic              LutWrEn,
  input  logic [TARG_W-1:0] LutWrAddr,
  input  logic [PC_W-1:0]   LutWrData,
  output logic [PC_W-1:0]   PC,
  output logic              Running,
  output logic              Done,
  output logic [CNT_W-1:0]  CycleCount,
  output fetch_state_e      DbgState
);

  fetch_state_e     state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             running_q, running_d;
  logic             done_q, done_d;
  logic [PC_W-1:0]  lut_target;
  logic             lut_wr_en;

  // The table is only reprogrammable while the program is not executing.
  assign lut_wr_en = LutWrEn && (state_q != RUN);

  target_lut #(
    .PC_W (PC_W)
  ) u_target_lut (
    .clk     (Clk),
    .rst_n   (Reset_n),
    .wr_en   (lut_wr_en),
    .wr_addr (LutWrAddr),
    .wr_data (LutWrData),
    .rd_addr (TargSel),
    .rd_data (lut_target)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        pc_d = '0;
        if (Start) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        // Stalled cycles still count as time spent running.
        if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (!Stall) begin
          // Ack wins over Jump: the all-ones instruction raises both.
          if (Ack) begin
            state_d = HALT;
          end else if (Jump || (BranchEn && Taken)) begin
            pc_d = lut_target;
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
      end
      HALT: begin
        if (Start) begin
          state_d = RUN;
          pc_d    = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = '0;
      end
    endcase

    running_d = (state_d == RUN);
    done_d    = (state_d == HALT);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      cnt_q     <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign PC         = pc_q;
  assign Running    = running_q;
  assign Done       = done_q;
  assign CycleCount = cnt_q;
  assign DbgState   = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed program-flow scenarios followed by
// randomized decoder/ALU traffic, checked against a behavioural model.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int PC_W    = 10;
  localparam int CNT_W   = 6;
  localparam int W       = PC_W + 2 + CNT_W;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int PC_MOD  = 1 << PC_W;

  logic              Clk = 1'b0;
  logic              Reset_n;
  logic              Start, Stall, Jump, BranchEn, Ack, Taken, LutWrEn;
  logic [TARG_W-1:0] TargSel, LutWrAddr;
  logic [PC_W-1:0]   LutWrData;
  logic [PC_W-1:0]   PC;
  logic              Running, Done;
  logic [CNT_W-1:0]  CycleCount;
  fetch_state_e      DbgState;

  fetch_unit #(
    .PC_W  (PC_W),
    .CNT_W (CNT_W)
  ) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .Start      (Start),
    .Stall      (Stall),
    .Jump       (Jump),
    .BranchEn   (BranchEn),
    .TargSel    (TargSel),
    .Ack        (Ack),
    .Taken      (Taken),
    .LutWrEn    (LutWrEn),
    .LutWrAddr  (LutWrAddr),
    .LutWrData  (LutWrData),
    .PC         (PC),
    .Running    (Running),
    .Done       (Done),
    .CycleCount (CycleCount),
    .DbgState   (DbgState)
  );

  // clock
  always #5 Clk = ~Clk;

  logic [W-1:0] dut_out;
  assign dut_out = {PC, Running, Done, CycleCount};

  // scoreboard
  logic [W-1:0] exp_q[$];
  int compared   = 0;
  int mismatched = 0;

  // behavioural model: mode 0 = idle, 1 = running, 2 = halted
  int m_mode, m_pc, m_cnt;
  int m_lut[4];

  function automatic logic [W-1:0] model_out();
    logic [PC_W-1:0]  p;
    logic [CNT_W-1:0] c;
    p = PC_W'(m_pc);
    c = CNT_W'(m_cnt);
    return {p, (m_mode == 1), (m_mode == 2), c};
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_pc   = 0;
    m_cnt  = 0;
    for (int i = 0; i < 4; i++) m_lut[i] = 0;
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp_v);
    compared++;
    if (act !== exp_v) begin
      mismatched++;
      $display("FAIL %s @%0t: got pc=%03h run=%0b done=%0b cnt=%0d, expected pc=%03h run=%0b done=%0b cnt=%0d",
               name, $time, act[W-1 -: PC_W], act[CNT_W+1], act[CNT_W], act[CNT_W-1:0],
               exp_v[W-1 -: PC_W], exp_v[CNT_W+1], exp_v[CNT_W], exp_v[CNT_W-1:0]);
    end
  endtask

  // monitor: outputs are registered, so compare once per cycle mid-period
  always @(negedge Clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      check("cycle", dut_out, e);
    end
  end

  task automatic drive_idle();
    Start = 0; Stall = 0; Jump = 0; BranchEn = 0; TargSel = '0; Ack = 0; Taken = 0;
    LutWrEn = 0; LutWrAddr = '0; LutWrData = '0;
  endtask

  // One clock of stimulus: record what this cycle must show, apply inputs,
  // then advance the model to the following cycle.
  task automatic step(input logic st, input logic sl, input logic jp, input logic be,
                      input logic [1:0] ts, input logic ak, input logic tk,
                      input logic we, input logic [1:0] wa, input logic [PC_W-1:0] wd);
    @(posedge Clk);
    #1;
    exp_q.push_back(model_out());
    Start = st; Stall = sl; Jump = jp; BranchEn = be; TargSel = ts; Ack = ak; Taken = tk;
    LutWrEn = we; LutWrAddr = wa; LutWrData = wd;
    if (m_mode == 1) begin
      m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
      if (!sl) begin
        if (ak) m_mode = 2;
        else if (jp || (be && tk)) m_pc = m_lut[ts];
        else m_pc = (m_pc + 1) % PC_MOD;
      end
    end else begin
      if (we) m_lut[wa] = int'(wd);
      if (st) begin
        m_mode = 1;
        m_pc   = 0;
        m_cnt  = 0;
      end
    end
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, '0);
  endtask

  // Reset pulsed between edges; its effect must show before the next edge.
  task automatic async_reset_mid();
    @(posedge Clk);
    #6;
    Reset_n = 0;
    drive_idle();
    #1;
    check("async_reset", dut_out, '0);
    model_reset();
    @(posedge Clk);
    #1;
    Reset_n = 1;
  endtask

  initial begin
    drive_idle();
    model_reset();
    Reset_n = 1;
    #1;
    Reset_n = 0;
    #2;
    check("reset", dut_out, '0);
    @(posedge Clk);
    #1;
    Reset_n = 1;

    // basic sequential fetch
    step(1, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, '0);
    nop(6);
    step(0, 0, 0, 0, 2'd0, 1, 0, 0, 2'd0, '0);
    nop(2);

    // program the table while halted, restart together with a write
    step(0, 0, 0, 0, 2'd0, 0, 0, 1, 2'd2, 10'h3F0);
    step(0, 0, 0, 0, 2'd0, 0, 0, 1, 2'd3, 10'h3FF);
    step(1, 0, 0, 0, 2'd0, 0, 0, 1, 2'd1, 10'h100);
    nop(3);
    step(0, 0, 1, 0, 2'd2, 0, 0, 0, 2'd0, '0);   // jump at PC 3
    step(0, 0, 0, 1, 2'd2, 0, 0, 0, 2'd0, '0);   // branch not taken
    step(0, 0, 0, 1, 2'd2, 0, 1, 0, 2'd0, '0);   // branch taken
    step(0, 0, 1, 0, 2'd3, 0, 0, 0, 2'd0, '0);   // to 0x3FF
    nop(1);                                      // wraps to 0
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 2'd2, 0, 0, 0, 2'd0, '0);
    for (int i = 0; i < 2; i++) step(0, 1, 0, 0, 2'd0, 1, 0, 0, 2'd0, '0);
    step(0, 0, 0, 0, 2'd0, 0, 0, 1, 2'd1, 10'h055); // dropped while running
    step(1, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, '0);      // ignored while running
    nop(5);
    step(0, 0, 1, 0, 2'd2, 1, 0, 0, 2'd0, '0);      // Ack beats Jump at PC 7
    nop(2);
    step(1, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, '0);
    step(0, 0, 1, 0, 2'd1, 0, 0, 0, 2'd0, '0);      // LUT[1] must still be 0x100
    nop(70);                                        // counter saturates
    async_reset_mid();
    step(1, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, '0);
    nop(2);
    step(0, 0, 1, 0, 2'd2, 0, 0, 0, 2'd0, '0);      // cleared table -> 0
    nop(2);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        async_reset_mid();
      end else begin
        step($urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0,
             $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
             2'($urandom_range(0, 3)), $urandom_range(0, 29) == 0,
             1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0,
             2'($urandom_range(0, 3)), 10'($urandom_range(0, 1023)));
      end
    end

    @(posedge Clk);
    #1;
    drive_idle();
    @(negedge Clk);
    #1;
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
